// File: rtl/pipelined_floating_point_multiplier_if.sv
// Operand/result bundle for pipelined_floating_point_multiplier.
// master: operand scheduler plus result consumer; slave: the multiplier itself.
interface pipelined_floating_point_multiplier_if #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int TAG_WIDTH      = 4
);
  localparam int W = EXPONENT_WIDTH + MANTISSA_WIDTH + 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [W-1:0]         a;
  logic [W-1:0]         b;
  logic                 round_to_nearest;
  logic [TAG_WIDTH-1:0] in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [W-1:0]         out;
  logic [TAG_WIDTH-1:0] out_tag;
  logic                 underflow_flag;
  logic                 overflow_flag;
  logic                 invalid_operation_flag;

  modport master (
    output in_valid, a, b, round_to_nearest, in_tag, out_ready,
    input  in_ready, out_valid, out, out_tag,
           underflow_flag, overflow_flag, invalid_operation_flag
  );

  modport slave (
    input  in_valid, a, b, round_to_nearest, in_tag, out_ready,
    output in_ready, out_valid, out, out_tag,
           underflow_flag, overflow_flag, invalid_operation_flag
  );
endinterface

// File: rtl/pipelined_floating_point_multiplier.sv
// Three-stage valid/ready floating-point multiplier:
//   S1 unpack/classify, S2 mantissa multiply + exponent sum, S3 normalise/round/pack.
// Results are flushed to zero instead of going subnormal.
// Optional feature macro: FP_MUL_STICKY_FLAGS_EN adds flags_clear and
// sticky_underflow/sticky_overflow/sticky_invalid accumulating flags over output transfers.
module pipelined_floating_point_multiplier #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int TAG_WIDTH      = 4
) (
  input  logic clk,
  input  logic rst,
`ifdef FP_MUL_STICKY_FLAGS_EN
  input  logic flags_clear,
  output logic sticky_underflow,
  output logic sticky_overflow,
  output logic sticky_invalid,
`endif
  pipelined_floating_point_multiplier_if.slave bus
);
  localparam int W   = EXPONENT_WIDTH + MANTISSA_WIDTH + 1;
  localparam int P   = MANTISSA_WIDTH + 1;
  localparam int PW  = 2 * P;
  localparam int EXW = EXPONENT_WIDTH + 2;

  localparam logic signed [EXW-1:0] BIAS        = EXW'((1 << (EXPONENT_WIDTH - 1)) - 1);
  localparam logic signed [EXW-1:0] ALL_ONES    = EXW'((1 << EXPONENT_WIDTH) - 1);
  localparam logic signed [EXW-1:0] ALL_ONES_M1 = EXW'((1 << EXPONENT_WIDTH) - 2);
  localparam logic [P-1:0]          HALF        = {1'b1, {MANTISSA_WIDTH{1'b0}}};

  // E4M3 has no infinity encoding spare, so its NaN uses the all-ones mantissa
  localparam logic [MANTISSA_WIDTH-1:0] NAN_FRAC =
    (EXPONENT_WIDTH == 4 && MANTISSA_WIDTH == 3) ? {MANTISSA_WIDTH{1'b1}}
                                                 : {1'b1, {(MANTISSA_WIDTH-1){1'b0}}};
  localparam logic [W-1:0] QNAN = {1'b1, {EXPONENT_WIDTH{1'b1}}, NAN_FRAC};

  // operand fields
  logic [EXPONENT_WIDTH-1:0] a_exp, b_exp;
  logic [MANTISSA_WIDTH-1:0] a_frac, b_frac;
  assign a_exp  = bus.a[W-2:MANTISSA_WIDTH];
  assign b_exp  = bus.b[W-2:MANTISSA_WIDTH];
  assign a_frac = bus.a[MANTISSA_WIDTH-1:0];
  assign b_frac = bus.b[MANTISSA_WIDTH-1:0];

  // pipeline state
  logic                      s1_valid, s1_sign, s1_rne;
  logic [EXPONENT_WIDTH-1:0] s1_ea, s1_eb;
  logic [P-1:0]              s1_ma, s1_mb;
  logic [TAG_WIDTH-1:0]      s1_tag;
  logic                      s1_a_zero, s1_a_inf, s1_a_qnan, s1_a_snan;
  logic                      s1_b_zero, s1_b_inf, s1_b_qnan, s1_b_snan;

  logic                      s2_valid, s2_sign, s2_rne;
  logic [PW-1:0]             s2_prod;
  logic signed [EXW-1:0]     s2_exp;
  logic [TAG_WIDTH-1:0]      s2_tag;
  logic                      s2_nan, s2_nan_inv, s2_zero_inf, s2_zero;

  logic                      out_valid_r, uf_r, of_r, inv_r;
  logic [W-1:0]              out_r;
  logic [TAG_WIDTH-1:0]      out_tag_r;

  // a stage may load when it is empty or when its content moves on downstream
  logic ld1, ld2, ld3, in_fire;
  assign ld3          = !out_valid_r || bus.out_ready;
  assign ld2          = !s2_valid || ld3;
  assign ld1          = !s1_valid || ld2;
  assign bus.in_ready = ld3;
  assign in_fire      = bus.in_valid && ld3;

  // S1: latch operands and classify each one
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (ld1) begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_sign   <= bus.a[W-1] ^ bus.b[W-1];
        s1_rne    <= bus.round_to_nearest;
        s1_tag    <= bus.in_tag;
        s1_ea     <= a_exp;
        s1_eb     <= b_exp;
        s1_ma     <= {|a_exp, a_frac};
        s1_mb     <= {|b_exp, b_frac};
        s1_a_zero <= (a_exp == '0) && (a_frac == '0);
        s1_b_zero <= (b_exp == '0) && (b_frac == '0);
        s1_a_inf  <= (&a_exp) && (a_frac == '0);
        s1_b_inf  <= (&b_exp) && (b_frac == '0);
        s1_a_qnan <= (&a_exp) && a_frac[MANTISSA_WIDTH-1];
        s1_b_qnan <= (&b_exp) && b_frac[MANTISSA_WIDTH-1];
        s1_a_snan <= (&a_exp) && !a_frac[MANTISSA_WIDTH-1] && (a_frac != '0);
        s1_b_snan <= (&b_exp) && !b_frac[MANTISSA_WIDTH-1] && (b_frac != '0);
      end
    end
  end

  // S2: full mantissa product, biased exponent sum and special-case summary
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (ld2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_prod     <= {{P{1'b0}}, s1_ma} * {{P{1'b0}}, s1_mb};
        s2_exp      <= $signed({2'b00, s1_ea}) + $signed({2'b00, s1_eb}) - BIAS;
        s2_sign     <= s1_sign;
        s2_rne      <= s1_rne;
        s2_tag      <= s1_tag;
        s2_nan      <= s1_a_qnan || s1_a_snan || s1_b_qnan || s1_b_snan;
        s2_nan_inv  <= s1_a_snan || s1_b_snan || (s1_a_qnan ^ s1_b_qnan);
        s2_zero_inf <= (s1_a_zero && s1_b_inf) || (s1_a_inf && s1_b_zero);
        s2_zero     <= s1_a_zero || s1_b_zero;
      end
    end
  end

  // S3 datapath
  logic                      prod_msb, round_up;
  logic [MANTISSA_WIDTH-1:0] frac;
  logic [P-1:0]              rbits, frac_r;
  logic signed [EXW-1:0]     exp_n, exp_r;
  logic [W-1:0]              res;
  logic                      res_uf, res_of, res_inv;

  // S3: normalise, round and pick the result by exception priority
  always_comb begin
    prod_msb = s2_prod[PW-1];
    frac     = prod_msb ? s2_prod[PW-2:P] : s2_prod[PW-3:P-1];
    rbits    = prod_msb ? s2_prod[P-1:0] : {s2_prod[P-2:0], 1'b0};
    round_up = s2_rne && ((rbits > HALF) || ((rbits == HALF) && frac[0]));
    frac_r   = {1'b0, frac} + {{MANTISSA_WIDTH{1'b0}}, round_up};
    exp_n    = s2_exp + {{(EXW-1){1'b0}}, prod_msb};
    exp_r    = exp_n + {{(EXW-1){1'b0}}, frac_r[MANTISSA_WIDTH]};
    res      = '0;
    res_uf   = 1'b0;
    res_of   = 1'b0;
    res_inv  = 1'b0;
    if (s2_nan) begin
      res     = QNAN;
      res_inv = s2_nan_inv;
    end else if (s2_zero_inf) begin
      res     = QNAN;
      res_inv = 1'b1;
    end else if (s2_zero) begin
      res = {s2_sign, {(W-1){1'b0}}};
    end else if (s2_exp[EXW-1] || ((s2_exp == '0) && !prod_msb)) begin
      res    = {s2_sign, {(W-1){1'b0}}};
      res_uf = 1'b1;
    end else if ((s2_exp >= ALL_ONES) || ((s2_exp == ALL_ONES_M1) && prod_msb)
                 || (exp_r == ALL_ONES)) begin
      res    = {s2_sign, {EXPONENT_WIDTH{1'b1}}, {MANTISSA_WIDTH{1'b0}}};
      res_of = 1'b1;
    end else begin
      res = {s2_sign, exp_r[EXPONENT_WIDTH-1:0], frac_r[MANTISSA_WIDTH-1:0]};
    end
  end

  // output register: holds steady while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_r       <= '0;
      out_tag_r   <= '0;
      uf_r        <= 1'b0;
      of_r        <= 1'b0;
      inv_r       <= 1'b0;
    end else if (ld3) begin
      out_valid_r <= s2_valid;
      if (s2_valid) begin
        out_r     <= res;
        out_tag_r <= s2_tag;
        uf_r      <= res_uf;
        of_r      <= res_of;
        inv_r     <= res_inv;
      end
    end
  end

  assign bus.out_valid              = out_valid_r;
  assign bus.out                    = out_r;
  assign bus.out_tag                = out_tag_r;
  assign bus.underflow_flag         = uf_r;
  assign bus.overflow_flag          = of_r;
  assign bus.invalid_operation_flag = inv_r;

`ifdef FP_MUL_STICKY_FLAGS_EN
  logic out_fire;
  assign out_fire = out_valid_r && bus.out_ready;

  // sticky flags: clear request loses to a transfer setting a bit in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_underflow <= 1'b0;
      sticky_overflow  <= 1'b0;
      sticky_invalid   <= 1'b0;
    end else begin
      sticky_underflow <= (sticky_underflow && !flags_clear) || (out_fire && uf_r);
      sticky_overflow  <= (sticky_overflow  && !flags_clear) || (out_fire && of_r);
      sticky_invalid   <= (sticky_invalid   && !flags_clear) || (out_fire && inv_r);
    end
  end
`endif
endmodule

// File: tb/tb_pipelined_floating_point_multiplier.sv
// Self-checking bench for pipelined_floating_point_multiplier (FP32 defaults).
// Directed vectors carry literal expectations; random ones use an arithmetic model.
module tb_pipelined_floating_point_multiplier;
  typedef struct packed {
    logic [31:0] value;
    logic        uf;
    logic        of;
    logic        inv;
    logic [3:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   accept_count = 0;
  int   out_count = 0;
  exp_t exp_q[$];
  bit   drv_use_lit = 1'b0;
  exp_t drv_lit = '0;
  bit   rand_done = 1'b0;
  logic stall_prev = 1'b0;
  logic [38:0] held = '0;

  pipelined_floating_point_multiplier_if bus_if ();

`ifdef FP_MUL_STICKY_FLAGS_EN
  logic flags_clear = 1'b0;
  logic sticky_underflow, sticky_overflow, sticky_invalid;
`endif

  pipelined_floating_point_multiplier dut (
    .clk(clk),
    .rst(rst),
`ifdef FP_MUL_STICKY_FLAGS_EN
    .flags_clear(flags_clear),
    .sticky_underflow(sticky_underflow),
    .sticky_overflow(sticky_overflow),
    .sticky_invalid(sticky_invalid),
`endif
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, expv, $time);
    end
  endtask

  // Reference: exact integer product, then the exception rules and rounding applied in order
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic rne, input logic [3:0] tag);
    exp_t r;
    int ea, eb, e, shift;
    bit a_nan, b_nan, a_q, b_q, a_s, b_s, a_inf, b_inf, a_zero, b_zero, sign, top;
    longint unsigned ma, mb, prod, keep, rem, half;
    r = '0;
    r.tag = tag;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    a_q    = a_nan && a[22];
    b_q    = b_nan && b[22];
    a_s    = a_nan && !a[22];
    b_s    = b_nan && !b[22];
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0) && (a[22:0] == 0);
    b_zero = (eb == 0) && (b[22:0] == 0);
    sign   = a[31] ^ b[31];
    if (a_nan || b_nan) begin
      r.value = 32'hFFC00000;
      r.inv   = a_s || b_s || (a_q != b_q);
      return r;
    end
    if ((a_zero && b_inf) || (a_inf && b_zero)) begin
      r.value = 32'hFFC00000;
      r.inv   = 1'b1;
      return r;
    end
    if (a_zero || b_zero) begin
      r.value = {sign, 31'h0};
      return r;
    end
    ma   = (ea != 0 ? 64'd1 << 23 : 64'd0) + 64'(a[22:0]);
    mb   = (eb != 0 ? 64'd1 << 23 : 64'd0) + 64'(b[22:0]);
    prod = ma * mb;
    e    = ea + eb - 127;
    top  = prod >= (64'd1 << 47);
    if (e < 0 || (e == 0 && !top)) begin
      r.value = {sign, 31'h0};
      r.uf    = 1'b1;
      return r;
    end
    if (e >= 255 || (e == 254 && top)) begin
      r.value = {sign, 8'hFF, 23'h0};
      r.of    = 1'b1;
      return r;
    end
    shift = top ? 24 : 23;
    e     = e + (top ? 1 : 0);
    keep  = prod >> shift;
    rem   = prod - (keep << shift);
    half  = 64'd1 << (shift - 1);
    if (rne && (rem > half || (rem == half && keep[0]))) keep = keep + 1;
    if (keep == (64'd1 << 24)) begin
      keep = 64'd1 << 23;
      e    = e + 1;
    end
    if (e >= 255) begin
      r.value = {sign, 8'hFF, 23'h0};
      r.of    = 1'b1;
      return r;
    end
    r.value = {sign, e[7:0], keep[22:0]};
    return r;
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] x;
    int sel, sp;
    x   = $urandom;
    sel = $urandom_range(0, 9);
    if (sel <= 5) x[30:23] = 8'($urandom_range(100, 154));
    else if (sel == 6) begin
      sp = $urandom_range(0, 5);
      if (sp == 0) x = 32'h0000_0000;
      else if (sp == 1) x = 32'h8000_0000;
      else if (sp == 2) x = {x[31], 8'hFF, 23'h0};
      else if (sp == 3) x = {x[31], 8'hFF, 1'b1, x[21:0]};
      else if (sp == 4) x = {x[31], 8'hFF, 1'b0, x[21:1], 1'b1};
      else x[30:23] = 8'h00;
    end
    else if (sel == 8) x[30:23] = 8'($urandom_range(190, 254));
    else if (sel == 9) x[30:23] = 8'($urandom_range(1, 70));
    return x;
  endfunction

  // scoreboard: record accepted operands, compare delivered results in FIFO order
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checkOutput("stall_valid", 64'(bus_if.out_valid), 64'd1);
        checkOutput("stall_hold", 64'({bus_if.out, bus_if.underflow_flag, bus_if.overflow_flag,
                                       bus_if.invalid_operation_flag, bus_if.out_tag}), 64'(held));
      end
      if (bus_if.out_valid && bus_if.out_ready) begin
        if (exp_q.size() == 0) checkOutput("unexpected_out", 64'(bus_if.out_valid), 64'd0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("result", 64'(bus_if.out), 64'(e.value));
          checkOutput("flags_tag", 64'({bus_if.underflow_flag, bus_if.overflow_flag,
                                        bus_if.invalid_operation_flag, bus_if.out_tag}),
                      64'({e.uf, e.of, e.inv, e.tag}));
          out_count++;
        end
      end
      stall_prev = bus_if.out_valid && !bus_if.out_ready;
      held = {bus_if.out, bus_if.underflow_flag, bus_if.overflow_flag,
              bus_if.invalid_operation_flag, bus_if.out_tag};
      if (bus_if.in_valid && bus_if.in_ready) begin
        exp_q.push_back(drv_use_lit ? drv_lit
                                    : model(bus_if.a, bus_if.b, bus_if.round_to_nearest, bus_if.in_tag));
        accept_count++;
      end
    end
  end

  // present one operand pair from posedge+1 until it is accepted
  task automatic applyStimulus(input logic [31:0] a_v, input logic [31:0] b_v, input logic rne,
                               input logic [3:0] tag, input bit use_lit, input exp_t lit);
    bit accepted;
    int waited;
    accepted = 1'b0;
    waited   = 0;
    bus_if.a = a_v;
    bus_if.b = b_v;
    bus_if.round_to_nearest = rne;
    bus_if.in_tag = tag;
    bus_if.in_valid = 1'b1;
    drv_use_lit = use_lit;
    drv_lit = lit;
    while (!accepted && waited < 300) begin
      @(negedge clk);
      if (bus_if.in_ready) accepted = 1'b1;
      else waited++;
    end
    if (!accepted) checkOutput("accept_in_ready", 64'(bus_if.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    drv_use_lit = 1'b0;
  endtask

  task automatic drainPipeline();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus_if.out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int edges, acc0, out0;
    bus_if.in_valid = 1'b0;
    bus_if.a = '0;
    bus_if.b = '0;
    bus_if.round_to_nearest = 1'b0;
    bus_if.in_tag = '0;
    bus_if.out_ready = 1'b1;
    rst = 1'b1;

    // reset state
    @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 64'(bus_if.out_valid), 64'd0);
    checkOutput("reset_out", 64'(bus_if.out), 64'd0);
    checkOutput("reset_out_tag", 64'(bus_if.out_tag), 64'd0);
    checkOutput("reset_flags", 64'({bus_if.underflow_flag, bus_if.overflow_flag,
                                    bus_if.invalid_operation_flag}), 64'd0);
    checkOutput("reset_in_ready", 64'(bus_if.in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // latency: 1.5 * 2.0 = 3.0
    applyStimulus(32'h3FC00000, 32'h40000000, 1'b1, 4'd1, 1'b1, '{32'h40400000, 1'b0, 1'b0, 1'b0, 4'd1});
    edges = 1;
    while (!bus_if.out_valid && edges < 10) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput("latency", 64'(edges), 64'd3);
    drainPipeline();

    // back-to-back with mixed rounding modes
    applyStimulus(32'h3FC00001, 32'h3FC00001, 1'b1, 4'd2, 1'b1, '{32'h40100002, 1'b0, 1'b0, 1'b0, 4'd2});
    applyStimulus(32'h3FC00001, 32'h3FC00001, 1'b0, 4'd3, 1'b1, '{32'h40100001, 1'b0, 1'b0, 1'b0, 4'd3});
    applyStimulus(32'h3FC00001, 32'h3FC00001, 1'b1, 4'd4, 1'b1, '{32'h40100002, 1'b0, 1'b0, 1'b0, 4'd4});
    drainPipeline();

    // exceptions
    applyStimulus(32'h00000000, 32'h7F800000, 1'b1, 4'd5, 1'b1, '{32'hFFC00000, 1'b0, 1'b0, 1'b1, 4'd5});
    applyStimulus(32'h7F000000, 32'h7F000000, 1'b1, 4'd6, 1'b1, '{32'h7F800000, 1'b0, 1'b1, 1'b0, 4'd6});
    applyStimulus(32'h00800000, 32'h00800000, 1'b1, 4'd7, 1'b1, '{32'h00000000, 1'b1, 1'b0, 1'b0, 4'd7});
    applyStimulus(32'h7FC00000, 32'h3F800000, 1'b1, 4'd8, 1'b1, '{32'hFFC00000, 1'b0, 1'b0, 1'b1, 4'd8});
    applyStimulus(32'h7FC00000, 32'hFFC00000, 1'b1, 4'd9, 1'b1, '{32'hFFC00000, 1'b0, 1'b0, 1'b0, 4'd9});
    applyStimulus(32'hC0000000, 32'h00000000, 1'b1, 4'd10, 1'b1, '{32'h80000000, 1'b0, 1'b0, 1'b0, 4'd10});
    drainPipeline();

    // backpressure: six operations against a stalled consumer
    bus_if.out_ready = 1'b0;
    acc0 = accept_count;
    out0 = out_count;
    fork
      begin
        for (int i = 0; i < 6; i++)
          applyStimulus(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)), 4'(8 + i), 1'b0, '0);
      end
      begin
        repeat (6) @(posedge clk);
        #2;
        checkOutput("bp_accepted", 64'(accept_count - acc0), 64'd3);
        checkOutput("bp_in_ready", 64'(bus_if.in_ready), 64'd0);
        bus_if.out_ready = 1'b1;
      end
    join
    drainPipeline();
    checkOutput("bp_delivered", 64'(out_count - out0), 64'd6);

    // reset with three operations in flight
    for (int i = 0; i < 3; i++)
      applyStimulus(rand_operand(), rand_operand(), 1'b1, 4'(i), 1'b0, '0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_flush_valid", 64'(bus_if.out_valid), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      checkOutput("no_stale", 64'(bus_if.out_valid), 64'd0);
    end

    // randomized traffic with a randomly stalling consumer
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++)
          applyStimulus(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)),
                        4'($urandom_range(0, 15)), 1'b0, '0);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          bus_if.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus_if.out_ready = 1'b1;
    drainPipeline();

`ifdef FP_MUL_STICKY_FLAGS_EN
    // sticky overflow survives a clean result and clears on request
    applyStimulus(32'h7F000000, 32'h7F000000, 1'b1, 4'd1, 1'b1, '{32'h7F800000, 1'b0, 1'b1, 1'b0, 4'd1});
    applyStimulus(32'h3FC00000, 32'h40000000, 1'b1, 4'd2, 1'b1, '{32'h40400000, 1'b0, 1'b0, 1'b0, 4'd2});
    drainPipeline();
    checkOutput("sticky_overflow_set", 64'(sticky_overflow), 64'd1);
    flags_clear = 1'b1;
    @(posedge clk);
    #1;
    flags_clear = 1'b0;
    checkOutput("sticky_cleared", 64'({sticky_underflow, sticky_overflow, sticky_invalid}), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
